// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: check-bit count, data-to-codeword position map and
// per-check-bit coverage masks, all evaluated at elaboration time.
package ecc_pkg;

  localparam int unsigned MAX_DATA_W = 120;

  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int unsigned ham_width(input int unsigned data_w);
    int unsigned r;
    r = 0;
    for (int k = 7; k >= 1; k--) begin
      if ((32'd1 << k) >= data_w + k + 1) r = k;
    end
    return r;
  endfunction

  // Position of data bit d: the d-th non-power-of-two position, ascending from 3.
  function automatic int unsigned data_pos(input int unsigned d);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 3; p < 256; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == d) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] cov_mask(input int unsigned data_w,
                                                     input int unsigned i);
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    for (int unsigned d = 0; d < MAX_DATA_W; d++) begin
      if (d < data_w && ((data_pos(d) >> i) & 1) != 0) m[d] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ecc_hamming_gen.sv
// Combinational check-bit generator: HAM_W Hamming bits plus overall parity on top.
module ecc_hamming_gen
  import ecc_pkg::*;
#(
  parameter int unsigned  DATA_W = 32,
  localparam int unsigned HAM_W  = ham_width(DATA_W),
  localparam int unsigned CHK_W  = HAM_W + 1
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [CHK_W-1:0]  o_chk
);

  logic [HAM_W-1:0] w_ham;

  for (genvar gi = 0; gi < HAM_W; gi++) begin : g_chk
    localparam logic [MAX_DATA_W-1:0] MASK = cov_mask(DATA_W, gi);
    assign w_ham[gi] = ^(i_data & MASK[DATA_W-1:0]);
  end

  assign o_chk = {(^i_data) ^ (^w_ham), w_ham};

endmodule

// File: rtl/ecc_secded_codec.sv
// SECDED codec: 1-cycle registered encoder and 2-stage decoder/corrector with
// valid-qualified error flags and saturating, clearable event counters.
module ecc_secded_codec
  import ecc_pkg::*;
#(
  parameter int unsigned  DATA_W = 32,
  parameter int unsigned  CNT_W  = 16,
  localparam int unsigned HAM_W  = ham_width(DATA_W),
  localparam int unsigned CHK_W  = HAM_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enc_valid,
  input  logic [DATA_W-1:0] i_enc_in,
  output logic              o_enc_out_valid,
  output logic [DATA_W-1:0] o_enc_out,
  output logic [CHK_W-1:0]  o_parity_out,
  input  logic              i_dec_valid,
  input  logic [DATA_W-1:0] i_dec_data_in,
  input  logic [CHK_W-1:0]  i_dec_parity_in,
  output logic              o_dec_out_valid,
  output logic [DATA_W-1:0] o_dec_out,
  output logic              o_dec_sec,
  output logic              o_dec_ded,
  output logic [HAM_W-1:0]  o_dec_syndrome,
  input  logic              i_cnt_clear,
  output logic [CNT_W-1:0]  o_sec_count,
  output logic [CNT_W-1:0]  o_ded_count
);

  localparam logic [HAM_W-1:0] MAX_POS = HAM_W'(DATA_W + HAM_W);

  logic              r_enc_valid;
  logic [DATA_W-1:0] r_enc_data;
  logic              r_dec_v1;
  logic [DATA_W-1:0] r_dec_data;
  logic [CHK_W-1:0]  r_dec_par;
  logic              r_dec_v2;
  logic [DATA_W-1:0] r_dec_out;
  logic              r_dec_sec;
  logic              r_dec_ded;
  logic [HAM_W-1:0]  r_dec_syn;
  logic [CNT_W-1:0]  r_sec_cnt;
  logic [CNT_W-1:0]  r_ded_cnt;

  logic [CHK_W-1:0]  w_dchk;
  logic [HAM_W-1:0]  w_syn;
  logic              w_pmis;
  logic              w_impossible;
  logic [DATA_W-1:0] w_flip;
  logic              w_sec;
  logic              w_ded;

  ecc_hamming_gen #(.DATA_W(DATA_W)) u_enc_gen (
    .i_data(r_enc_data),
    .o_chk (o_parity_out)
  );

  ecc_hamming_gen #(.DATA_W(DATA_W)) u_dec_gen (
    .i_data(r_dec_data),
    .o_chk (w_dchk)
  );

  assign w_syn = w_dchk[HAM_W-1:0] ^ r_dec_par[HAM_W-1:0];
  // Overall parity of received word, rewritten via the generator's top bit.
  assign w_pmis       = w_dchk[CHK_W-1] ^ (^w_syn) ^ r_dec_par[CHK_W-1];
  assign w_impossible = (w_syn > MAX_POS);

  for (genvar gd = 0; gd < DATA_W; gd++) begin : g_flip
    localparam logic [HAM_W-1:0] POS = HAM_W'(data_pos(gd));
    assign w_flip[gd] = w_pmis && (w_syn == POS);
  end

  assign w_sec = r_dec_v1 && w_pmis && !w_impossible;
  assign w_ded = r_dec_v1 && ((w_pmis && w_impossible) || (!w_pmis && (w_syn != '0)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_enc_valid <= 1'b0;
      r_enc_data  <= '0;
      r_dec_v1    <= 1'b0;
      r_dec_data  <= '0;
      r_dec_par   <= '0;
      r_dec_v2    <= 1'b0;
      r_dec_out   <= '0;
      r_dec_sec   <= 1'b0;
      r_dec_ded   <= 1'b0;
      r_dec_syn   <= '0;
    end else begin
      r_enc_valid <= i_enc_valid;
      r_enc_data  <= i_enc_in;
      r_dec_v1    <= i_dec_valid;
      r_dec_data  <= i_dec_data_in;
      r_dec_par   <= i_dec_parity_in;
      r_dec_v2    <= r_dec_v1;
      r_dec_out   <= r_dec_data ^ w_flip;
      r_dec_sec   <= w_sec;
      r_dec_ded   <= w_ded;
      r_dec_syn   <= w_syn;
    end
  end

  // Counters advance on the same edge that registers the flag.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clear) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else begin
      if (w_sec && (r_sec_cnt != '1)) r_sec_cnt <= r_sec_cnt + 1'b1;
      if (w_ded && (r_ded_cnt != '1)) r_ded_cnt <= r_ded_cnt + 1'b1;
    end
  end

  assign o_enc_out_valid = r_enc_valid;
  assign o_enc_out       = r_enc_data;
  assign o_dec_out_valid = r_dec_v2;
  assign o_dec_out       = r_dec_out;
  assign o_dec_sec       = r_dec_sec;
  assign o_dec_ded       = r_dec_ded;
  assign o_dec_syndrome  = r_dec_syn;
  assign o_sec_count     = r_sec_cnt;
  assign o_ded_count     = r_ded_cnt;

endmodule

// File: tb/tb_ecc_secded_codec.sv
// Scoreboard bench for ecc_secded_codec (DATA_W=32, CNT_W=2) with a bit-level
// codeword reference model.
module tb_ecc_secded_codec;

  typedef struct packed {
    logic [31:0] data;
    logic        sec;
    logic        ded;
    logic [5:0]  syn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_valid;
  logic [31:0] enc_in;
  logic        enc_out_valid;
  logic [31:0] enc_out;
  logic [6:0]  parity_out;
  logic        dec_valid;
  logic [31:0] dec_data_in;
  logic [6:0]  dec_parity_in;
  logic        dec_out_valid;
  logic [31:0] dec_out;
  logic        dec_sec;
  logic        dec_ded;
  logic [5:0]  dec_syndrome;
  logic        cnt_clear;
  logic [1:0]  sec_count;
  logic [1:0]  ded_count;

  int   checks = 0;
  int   errors = 0;
  int   exp_sec_cnt = 0;
  int   exp_ded_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ecc_secded_codec #(.DATA_W(32), .CNT_W(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enc_valid    (enc_valid),
    .i_enc_in       (enc_in),
    .o_enc_out_valid(enc_out_valid),
    .o_enc_out      (enc_out),
    .o_parity_out   (parity_out),
    .i_dec_valid    (dec_valid),
    .i_dec_data_in  (dec_data_in),
    .i_dec_parity_in(dec_parity_in),
    .o_dec_out_valid(dec_out_valid),
    .o_dec_out      (dec_out),
    .o_dec_sec      (dec_sec),
    .o_dec_ded      (dec_ded),
    .o_dec_syndrome (dec_syndrome),
    .i_cnt_clear    (cnt_clear),
    .o_sec_count    (sec_count),
    .o_ded_count    (ded_count)
  );

  function automatic logic [6:0] ref_par(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  p;
    int          k;
    cw = '0;
    p  = '0;
    k  = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int i = 0; i < 6; i++)
      for (int pos = 1; pos <= 38; pos++)
        if (((pos >> i) & 1) != 0) p[i] = p[i] ^ cw[pos];
    p[6] = (^d) ^ (^p[5:0]);
    return p;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] d, input logic [6:0] par);
    logic [38:0] cw;
    int          syn;
    int          k;
    logic        pmis;
    exp_t        e;
    cw  = '0;
    k   = 0;
    syn = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int i = 0; i < 6; i++) cw[1 << i] = par[i];
    for (int pos = 1; pos <= 38; pos++) if (cw[pos]) syn = syn ^ pos;
    pmis  = (^d) ^ (^par);
    e.syn = syn[5:0];
    e.sec = pmis && (syn <= 38);
    e.ded = (pmis && (syn > 38)) || (!pmis && (syn != 0));
    if (e.sec && syn != 0) cw[syn] = ~cw[syn];
    k = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        e.data[k] = cw[pos];
        k++;
      end
    end
    return e;
  endfunction

  task automatic idle_inputs();
    enc_valid     = 1'b0;
    enc_in        = '0;
    dec_valid     = 1'b0;
    dec_data_in   = '0;
    dec_parity_in = '0;
    cnt_clear     = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    enc_valid     = 1'b1;
    enc_in        = 32'hDEAD_BEEF;
    dec_valid     = 1'b1;
    dec_data_in   = 32'h1234_5678;
    dec_parity_in = 7'h55;
    cnt_clear     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({enc_out_valid, enc_out, parity_out, dec_out_valid, dec_out, dec_sec, dec_ded,
         dec_syndrome, sec_count, ded_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: enc_v=%b enc=%h par=%h dec_v=%b dec=%h sec=%b ded=%b syn=%0d",
               enc_out_valid, enc_out, parity_out, dec_out_valid, dec_out, dec_sec, dec_ded,
               dec_syndrome, " cnt=%0d/%0d, required all zero", sec_count, ded_count);
    end
    idle_inputs();
    rst = 1'b0;
    exp_sec_cnt = 0;
    exp_ded_cnt = 0;
  endtask

  task automatic test_encode();
    logic [31:0] vals[4] = '{32'h0000_0001, 32'hA5A5_A5A5, 32'h8000_0000, 32'h1357_9BDF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      enc_valid = 1'b1;
      enc_in    = vals[i];
      @(negedge clk);
      enc_valid = 1'b0;
      enc_in    = ~vals[i];
      checks++;
      if ({enc_out_valid, enc_out, parity_out} !== {1'b1, vals[i], ref_par(vals[i])}) begin
        errors++;
        $display("FAIL encode[%0d]: got v=%b data=%h par=%h, required v=1 data=%h par=%h",
                 i, enc_out_valid, enc_out, parity_out, vals[i], ref_par(vals[i]));
      end
    end
    checks++;
    if (ref_par(32'h1) !== 7'h43) begin
      errors++;
      $display("FAIL encode_ref_0x1: model par=%h, required 43", ref_par(32'h1));
    end
    @(negedge clk);
    checks++;
    if (enc_out_valid !== 1'b0 || enc_out !== ~vals[3]) begin
      errors++;
      $display("FAIL encode_no_valid: got v=%b data=%h, required v=0 data=%h",
               enc_out_valid, enc_out, ~vals[3]);
    end
  endtask

  task automatic test_roundtrip();
    logic [31:0] vals[2] = '{32'h0000_0000, 32'hFFFF_FFFF};
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      enc_valid = 1'b1;
      enc_in    = vals[i];
      @(negedge clk);
      enc_valid     = 1'b0;
      dec_valid     = 1'b1;
      dec_data_in   = enc_out;
      dec_parity_in = parity_out;
      sb.push_back(ref_dec(vals[i], ref_par(vals[i])));
      @(negedge clk);
      dec_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (!dec_out_valid || sb.size() == 0) begin
        errors++;
        $display("FAIL roundtrip_valid[%0d]: dec_out_valid=%b, required 1", i, dec_out_valid);
      end else begin
        e = sb.pop_front();
        if ({dec_out, dec_sec, dec_ded, dec_syndrome} !== {vals[i], 1'b0, 1'b0, 6'd0} ||
            {dec_out, dec_sec, dec_ded, dec_syndrome} !== e) begin
          errors++;
          $display("FAIL roundtrip[%0d]: got data=%h sec=%b ded=%b syn=%0d, required data=%h 0 0 0",
                   i, dec_out, dec_sec, dec_ded, dec_syndrome, vals[i]);
        end
      end
    end
    sb.delete();
  endtask

  // Drives a table of received words back-to-back and scores every output.
  task automatic test_decode_patterns(input logic [31:0] dq[$], input logic [6:0] pq[$],
                                      input string tag);
    exp_t e;
    int   n;
    n = dq.size();
    for (int cyc = 0; cyc < n + 3; cyc++) begin
      @(negedge clk);
      if (dec_out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_unexpected: dec_out_valid=1 with empty scoreboard", tag);
        end else begin
          e = sb.pop_front();
          if (e.sec && exp_sec_cnt < 3) exp_sec_cnt++;
          if (e.ded && exp_ded_cnt < 3) exp_ded_cnt++;
          if ({dec_out, dec_sec, dec_ded, dec_syndrome, sec_count, ded_count} !==
              {e.data, e.sec, e.ded, e.syn, 2'(exp_sec_cnt), 2'(exp_ded_cnt)}) begin
            errors++;
            $display("FAIL %s_out: got data=%h sec=%b ded=%b syn=%0d cnt=%0d/%0d, %s%h %b %b %0d %0d/%0d",
                     tag, dec_out, dec_sec, dec_ded, dec_syndrome, sec_count, ded_count,
                     "required ", e.data, e.sec, e.ded, e.syn, exp_sec_cnt, exp_ded_cnt);
          end
        end
      end
      if (cyc < n) begin
        dec_valid     = 1'b1;
        dec_data_in   = dq[cyc];
        dec_parity_in = pq[cyc];
        sb.push_back(ref_dec(dq[cyc], pq[cyc]));
      end else begin
        dec_valid = 1'b0;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d words never came out, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_errors();
    logic [31:0] dq[$];
    logic [6:0]  pq[$];
    logic [31:0] a;
    exp_t        e;
    a = 32'hA5A5_A5A5;
    dq = '{a ^ 32'h20, 32'h3, a, a, a ^ 32'hE000_0000};
    pq = '{ref_par(a), ref_par(32'h0), ref_par(a) ^ 7'h40, ref_par(a) ^ 7'h04, ref_par(a)};
    // Spot-check the model against the hand-derived syndromes first.
    e = ref_dec(dq[0], pq[0]);
    checks++;
    if ({e.syn, e.sec, e.data} !== {6'd10, 1'b1, a}) begin
      errors++;
      $display("FAIL model_bit5: syn=%0d sec=%b data=%h, required 10 1 %h", e.syn, e.sec, e.data, a);
    end
    e = ref_dec(dq[4], pq[4]);
    checks++;
    if ({e.syn, e.sec, e.ded} !== {6'd39, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL model_impossible: syn=%0d sec=%b ded=%b, required 39 0 1", e.syn, e.sec, e.ded);
    end
    test_decode_patterns(dq, pq, "errors");
    dq.delete();
    pq.delete();
    for (int i = 0; i < 6; i++) begin
      a = $urandom();
      dq.push_back(a ^ (32'h1 << $urandom_range(31, 0)));
      pq.push_back(ref_par(a) ^ ((i % 2 == 1) ? (7'h1 << $urandom_range(6, 0)) : 7'h0));
    end
    test_decode_patterns(dq, pq, "random");
  endtask

  task automatic test_saturate();
    logic [31:0] dq[$];
    logic [6:0]  pq[$];
    @(negedge clk);
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    exp_sec_cnt = 0;
    exp_ded_cnt = 0;
    checks++;
    if ({sec_count, ded_count} !== 4'h0) begin
      errors++;
      $display("FAIL clear_idle: cnt=%0d/%0d, required 0/0", sec_count, ded_count);
    end
    for (int i = 0; i < 5; i++) begin
      dq.push_back((32'h1111_0000 + i) ^ (32'h1 << (i * 7)));
      pq.push_back(ref_par(32'h1111_0000 + i));
    end
    test_decode_patterns(dq, pq, "saturate");
    checks++;
    if (sec_count !== 2'd3) begin
      errors++;
      $display("FAIL saturate_final: sec_count=%0d, required 3", sec_count);
    end
  endtask

  task automatic test_clear_same_cycle();
    @(negedge clk);
    dec_valid     = 1'b1;
    dec_data_in   = 32'hCAFE_F00D ^ 32'h100;
    dec_parity_in = ref_par(32'hCAFE_F00D);
    @(negedge clk);
    dec_valid = 1'b0;
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    checks++;
    if ({dec_out_valid, dec_sec, dec_out, sec_count, ded_count} !==
        {1'b1, 1'b1, 32'hCAFE_F00D, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL clear_vs_sec: v=%b sec=%b data=%h cnt=%0d/%0d, required 1 1 cafef00d 0/0",
               dec_out_valid, dec_sec, dec_out, sec_count, ded_count);
    end
    @(negedge clk);
    checks++;
    if ({dec_out_valid, dec_sec, dec_ded} !== 3'b000) begin
      errors++;
      $display("FAIL flags_qualified: v=%b sec=%b ded=%b, required 000",
               dec_out_valid, dec_sec, dec_ded);
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    @(negedge clk);
    enc_valid     = 1'b1;
    enc_in        = 32'h0F0F_0F0F;
    dec_valid     = 1'b1;
    dec_data_in   = 32'h0F0F_0F0F ^ 32'h4;
    dec_parity_in = ref_par(32'h0F0F_0F0F);
    @(negedge clk);
    dec_data_in   = 32'h7777_7777 ^ 32'h3;
    dec_parity_in = ref_par(32'h7777_7777);
    rst           = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dec_out_valid || enc_out_valid || sec_count != 0 || ded_count != 0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_midstream: %0d cycles with valid output or nonzero count, required 0",
               seen);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_encode();
    test_roundtrip();
    test_errors();
    test_saturate();
    test_clear_same_cycle();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/ecc_secded_codec.md
Name: ecc_secded_codec

Overview:
- Parametrised SECDED Hamming codec: registered encoder plus pipelined decoder/corrector with error flags and saturating error counters.
- Generalises the fixed 32-bit encoder to any data width, using the same parity layout, so existing 32-bit check words stay bit-compatible.
- Sits on paths that store data in memory or cross links, e.g. the configuration and readout FIFOs: encode before the write, decode after the read.

Parameters:
- DATA_W, 32, data width in bits; legal range 4..120.
- CNT_W, 16, width of each error counter.
- HAM_W, derived localparam: smallest r with 2^r >= DATA_W+r+1 (6 for DATA_W=32).
- CHK_W, derived localparam: HAM_W+1 (7 for DATA_W=32); the top bit is the overall parity.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enc_valid  in  1  enc_in is valid this cycle.
- enc_in  in  DATA_W  data to encode.
- enc_out_valid  out  1  enc_out/parity_out are valid.
- enc_out  out  DATA_W  registered copy of enc_in.
- parity_out  out  CHK_W  check bits for enc_out.
- dec_valid  in  1  dec_data_in/dec_parity_in are valid.
- dec_data_in  in  DATA_W  received data.
- dec_parity_in  in  CHK_W  received check bits.
- dec_out_valid  out  1  decoder outputs are valid.
- dec_out  out  DATA_W  corrected data.
- dec_sec  out  1  single error detected and corrected (data or check bit).
- dec_ded  out  1  double error detected, uncorrectable.
- dec_syndrome  out  HAM_W  raw Hamming syndrome.
- cnt_clear  in  1  synchronous clear of both counters.
- sec_count  out  CNT_W  saturating count of dec_sec events.
- ded_count  out  CNT_W  saturating count of dec_ded events.

Behaviour:
- Codeword layout:
  - Positions are numbered 1..DATA_W+HAM_W.
  - Check bit i sits at position 2^i.
  - Data bit d takes the d-th non-power-of-two position, ascending: d0=3, d1=5, d2=6, d3=7, d4=9, ...
  - Check bit i = XOR of the data bits whose position has bit i set.
  - Check bit CHK_W-1 = XOR of all data bits and all HAM_W check bits.
- Encoder:
  - Latency 1.
  - On each clk: enc_out <= enc_in, enc_out_valid <= enc_valid. enc_out updates whether or not enc_valid is high.
  - parity_out is combinational from enc_out; no extra stage.
- Decoder, 2-stage pipeline, latency 2:
  - Stage 1: register the inputs and the valid bit.
  - Stage 1 to 2 logic:
    - syndrome = recomputed Hamming bits XOR received bits [HAM_W-1:0].
    - pmis = XOR of all received data and check bits, including the overall parity bit.
  - Stage 2: register dec_out, dec_sec, dec_ded, dec_syndrome and dec_out_valid.
- Decoder classification:
  - syndrome=0, pmis=0: no error; data passes through; sec=0, ded=0.
  - pmis=1: single error, sec=1.
    - If the syndrome matches a data position, invert that data bit.
    - If the syndrome is a power of two or 0, the error is in a check bit; data is unchanged.
    - If the syndrome exceeds DATA_W+HAM_W (impossible position), report ded=1 and sec=0 instead.
  - syndrome≠0, pmis=0: ded=1, data passed through uncorrected.
  - sec and ded are never both 1.
- Flags: dec_sec and dec_ded are qualified by valid; they are 0 whenever dec_out_valid=0.
- Counters:
  - Increment on the cycle dec_out_valid & dec_sec (or dec_out_valid & dec_ded) is registered.
  - Each counter saturates at 2^CNT_W-1.
  - cnt_clear has priority over increment: the counter becomes 0 and that cycle's event is not counted.
- Pipeline: no backpressure; a new word is accepted every cycle.
- Reset:
  - Clears all valid bits, enc_out, parity-source registers, dec_out, flags, syndrome and counters to 0.
  - Because enc_out=0 after reset, parity_out=0.
  - Reset mid-stream discards in-flight words: no valid output for 2 cycles after rst deasserts unless new input arrives.

Decomposition:
- Shared package ecc_pkg:
  - Function computing HAM_W from DATA_W.
  - Function mapping data index to codeword position.
  - Function returning the check-bit coverage mask for (DATA_W, i).
- One sub-module, ecc_hamming_gen (combinational, parametrised DATA_W): produces the CHK_W check bits from data. Instantiated once in the encoder and once in the decoder (the decoder feeds data only and compares against the received check bits).
- The counters stay inline.

Test Plan:
- DATA_W=32, enc_in=0x00000001, enc_valid=1 -> one cycle later enc_out=0x00000001, parity_out=7'h43.
- Encode 0x00000000 and 0xFFFFFFFF, feed each result to the decoder -> two cycles later dec_out equals the input, sec=0, ded=0, syndrome=0.
- Flip data bit 5 of an encoded 0xA5A5A5A5 -> dec_syndrome=10, dec_sec=1, dec_out=0xA5A5A5A5, sec_count=1.
- Flip data bits 0 and 1 -> dec_syndrome=6, dec_ded=1, dec_sec=0, dec_out equals the corrupted data, ded_count=1.
- Flip only parity bit 6 -> syndrome=0, dec_sec=1, data unchanged; flip only parity bit 2 -> syndrome=4, dec_sec=1, data unchanged.
- CNT_W=2, five consecutive single-error words -> sec_count sticks at 3.
  - cnt_clear asserted in the same cycle as a sec event -> count reads 0.
  - rst asserted between two in-flight words -> no dec_out_valid for them.
